// File: rtl/tx_ofdm_pkg.sv
// Shared 802.11a transmit definitions: modulation codes, per-mode
// interleaver constants (N_CBPS, N_CBPS/16, s) and small helpers.
package tx_ofdm_pkg;

  localparam int unsigned MAX_NCBPS = 288;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned ROW_W     = ADDR_W - 4;

  typedef enum logic [1:0] {
    MOD_BPSK  = 2'd0,
    MOD_QPSK  = 2'd1,
    MOD_16QAM = 2'd2,
    MOD_64QAM = 2'd3
  } mod_e;

  typedef enum logic {
    RD_IDLE,
    RD_READ
  } rd_state_e;

  localparam logic [ADDR_W-1:0] NCBPS_BPSK  = 9'd48;
  localparam logic [ADDR_W-1:0] NCBPS_QPSK  = 9'd96;
  localparam logic [ADDR_W-1:0] NCBPS_16QAM = 9'd192;
  localparam logic [ADDR_W-1:0] NCBPS_64QAM = 9'd288;

  localparam logic [4:0] N16_BPSK  = 5'd3;
  localparam logic [4:0] N16_QPSK  = 5'd6;
  localparam logic [4:0] N16_16QAM = 5'd12;
  localparam logic [4:0] N16_64QAM = 5'd18;

  localparam logic [1:0] S_BPSK  = 2'd1;
  localparam logic [1:0] S_QPSK  = 2'd1;
  localparam logic [1:0] S_16QAM = 2'd2;
  localparam logic [1:0] S_64QAM = 2'd3;

  function automatic logic [ADDR_W-1:0] ncbps_of(input mod_e m);
    case (m)
      MOD_BPSK:  return NCBPS_BPSK;
      MOD_QPSK:  return NCBPS_QPSK;
      MOD_16QAM: return NCBPS_16QAM;
      default:   return NCBPS_64QAM;
    endcase
  endfunction

  // v mod 3 without a divider: 2^n mod 3 is 1 for even n and 2 for odd n,
  // so a weighted bit sum (at most 7) reduces through a tiny table.
  function automatic logic [1:0] mod3_5b(input logic [4:0] v);
    logic [2:0] s;
    s = 3'(v[0]) + 3'(v[2]) + 3'(v[4]) + 3'({v[1], 1'b0}) + 3'({v[3], 1'b0});
    case (s)
      3'd0, 3'd3, 3'd6: return 2'd0;
      3'd1, 3'd4, 3'd7: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/tx_interleaver_if.sv
// Bit-stream bundle around the interleaver.
//   tx_Modulation, tx_puncture_valid, tx_puncture_bit : puncturer -> interleaver
//   tx_interleave_valid/_bit/_sof/_err                : interleaver -> mapper
// master = upstream/downstream environment, slave = the interleaver.
interface tx_interleaver_if;
  logic [1:0] tx_Modulation;
  logic       tx_puncture_valid;
  logic       tx_puncture_bit;
  logic       tx_interleave_valid;
  logic       tx_interleave_bit;
  logic       tx_interleave_sof;
  logic       tx_interleave_err;

  modport master (
    output tx_Modulation, tx_puncture_valid, tx_puncture_bit,
    input  tx_interleave_valid, tx_interleave_bit, tx_interleave_sof, tx_interleave_err
  );

  modport slave (
    input  tx_Modulation, tx_puncture_valid, tx_puncture_bit,
    output tx_interleave_valid, tx_interleave_bit, tx_interleave_sof, tx_interleave_err
  );
endinterface

// File: rtl/tx_interleave_addr_gen.sv
// Interleaver write-address generator: maps write counters (col = k mod 16,
// row = k div 16) and mode to the permuted address j. One registered stage.
//   clk_i, rst_i : clock, async active-high reset
//   col_i, row_i : write counters of the bit being accepted
//   mode_i       : modulation in force for that bit
//   addr_o       : j, valid one cycle after the inputs
module tx_interleave_addr_gen
  import tx_ofdm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        col_i,
  input  logic [ROW_W-1:0]  row_i,
  input  mod_e              mode_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] c_w;
  logic [ADDR_W-1:0] prod;
  logic [ADDR_W-1:0] i_w;
  logic [ADDR_W-1:0] j_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        i_m3;
  logic [1:0]        c_m3;
  logic [2:0]        rot;

  always_comb begin
    c_w  = ADDR_W'(col_i);
    // col * N_CBPS/16 as shift-adds (3, 6, 12, 18)
    case (mode_i)
      MOD_BPSK:  prod = (c_w << 1) + c_w;
      MOD_QPSK:  prod = (c_w << 2) + (c_w << 1);
      MOD_16QAM: prod = (c_w << 3) + (c_w << 2);
      default:   prod = (c_w << 4) + (c_w << 1);
    endcase
    i_w  = prod + ADDR_W'(row_i);
    // For 64-QAM N_CBPS/16 = 18 is a multiple of 3, so i mod 3 = row mod 3.
    i_m3 = mod3_5b(row_i);
    c_m3 = mod3_5b({1'b0, col_i});
    rot  = 3'(i_m3) + 3'd3 - 3'(c_m3);
    if (rot >= 3'd3) rot = rot - 3'd3;
    j_d  = i_w;
    if (mode_i == MOD_16QAM) begin
      j_d = {i_w[ADDR_W-1:1], i_w[0] ^ col_i[0]};
    end else if (mode_i == MOD_64QAM) begin
      j_d = i_w - ADDR_W'(i_m3) + ADDR_W'(rot);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) addr_q <= '0;
    else       addr_q <= j_d;
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/tx_interleaver.sv
// 802.11a transmit block interleaver. Collects one OFDM symbol of N_CBPS
// punctured bits into a ping-pong bank at permuted addresses, then streams
// the completed bank out sequentially (j = 0..N_CBPS-1) to the mapper.
//   clk_Modulation : clock, rising edge
//   reset          : async active-high reset
//   io (slave)     : tx_Modulation, tx_puncture_valid/_bit in;
//                    tx_interleave_valid/_bit/_sof/_err out
module tx_interleaver
  import tx_ofdm_pkg::*;
#(
  parameter int unsigned MAX_NCBPS = tx_ofdm_pkg::MAX_NCBPS
) (
  input  logic              clk_Modulation,
  input  logic              reset,
  tx_interleaver_if.slave   io
);

  // ---------------- writer ----------------
  logic [3:0]        col_q;
  logic [ROW_W-1:0]  row_q;
  mod_e              mod_q;
  logic              wr_bank_q, wr_bank_d;
  logic              k_zero;
  mod_e              cur_mod;
  logic [ADDR_W-1:0] cur_n;
  logic              in_last;

  // write-pipeline stage aligned with the registered address
  logic              vld_p_q, bit_p_q, bank_p_q, last_p_q;
  logic [ADDR_W-1:0] n_p_q;
  logic [ADDR_W-1:0] addr_j;

  logic [MAX_NCBPS-1:0] mem_q [2];

  // ---------------- reader ----------------
  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] rd_n_q, rd_n_d;
  logic              rd_bank_q, rd_bank_d;
  logic              out_valid_q, out_valid_d;
  logic              out_bit_q, out_bit_d;
  logic              out_sof_q, out_sof_d;
  logic              err_q, err_d;
  logic              handoff, rd_last, rd_free;

  assign k_zero  = (col_q == 4'd0) && (row_q == '0);
  assign cur_mod = k_zero ? mod_e'(io.tx_Modulation) : mod_q;
  assign cur_n   = ncbps_of(cur_mod);
  assign in_last = io.tx_puncture_valid && ({row_q, col_q} == cur_n - ADDR_W'(1));

  // The bank flips when the handoff is accepted, which is the same cycle the
  // first bit of the next symbol may be accepted; that bit takes the new bank.
  // A dropped handoff keeps the bank so the writer overwrites its own.
  assign wr_bank_d = wr_bank_q ^ (handoff & rd_free);

  tx_interleave_addr_gen u_addr_gen (
    .clk_i  (clk_Modulation),
    .rst_i  (reset),
    .col_i  (col_q),
    .row_i  (row_q),
    .mode_i (cur_mod),
    .addr_o (addr_j)
  );

  always_ff @(posedge clk_Modulation or posedge reset) begin
    if (reset) begin
      col_q     <= '0;
      row_q     <= '0;
      mod_q     <= MOD_BPSK;
      wr_bank_q <= 1'b0;
      vld_p_q   <= 1'b0;
      bit_p_q   <= 1'b0;
      bank_p_q  <= 1'b0;
      last_p_q  <= 1'b0;
      n_p_q     <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      vld_p_q   <= io.tx_puncture_valid;
      bit_p_q   <= io.tx_puncture_bit;
      bank_p_q  <= wr_bank_d;
      last_p_q  <= in_last;
      n_p_q     <= cur_n;
      if (io.tx_puncture_valid) begin
        if (k_zero) mod_q <= cur_mod;
        if (in_last) begin
          col_q <= '0;
          row_q <= '0;
        end else begin
          col_q <= col_q + 4'd1;
          if (col_q == 4'hF) row_q <= row_q + ROW_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_Modulation) begin
    if (vld_p_q) mem_q[bank_p_q][addr_j] <= bit_p_q;
  end

  assign handoff = vld_p_q & last_p_q;
  assign rd_last = (state_q == RD_READ) && (rd_addr_q == rd_n_q - ADDR_W'(1));
  // A reader on its final address is free: the next burst follows gap-free.
  assign rd_free = (state_q == RD_IDLE) || rd_last;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rd_n_d      = rd_n_q;
    rd_bank_d   = rd_bank_q;
    out_valid_d = 1'b0;
    out_bit_d   = 1'b0;
    out_sof_d   = 1'b0;
    err_d       = err_q;
    case (state_q)
      RD_READ: begin
        out_valid_d = 1'b1;
        out_bit_d   = mem_q[rd_bank_q][rd_addr_q];
        out_sof_d   = (rd_addr_q == '0);
        rd_addr_d   = rd_addr_q + ADDR_W'(1);
        if (rd_last) state_d = RD_IDLE;
      end
      default: ;
    endcase
    if (handoff) begin
      if (rd_free) begin
        state_d   = RD_READ;
        rd_addr_d = '0;
        rd_n_d    = n_p_q;
        rd_bank_d = bank_p_q;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_Modulation or posedge reset) begin
    if (reset) begin
      state_q     <= RD_IDLE;
      rd_addr_q   <= '0;
      rd_n_q      <= '0;
      rd_bank_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_sof_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      rd_n_q      <= rd_n_d;
      rd_bank_q   <= rd_bank_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_sof_q   <= out_sof_d;
      err_q       <= err_d;
    end
  end

  assign io.tx_interleave_valid = out_valid_q;
  assign io.tx_interleave_bit   = out_bit_q;
  assign io.tx_interleave_sof   = out_sof_q;
  assign io.tx_interleave_err   = err_q;

endmodule

// File: tb/tb_tx_interleaver.sv
// Scoreboard bench for tx_interleaver: the driver pushes expected output bits
// computed from the 802.11a interleaver formula; a negedge monitor pops and
// compares whenever the DUT presents a valid bit.
module tb_tx_interleaver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_interleaver_if io ();

  tx_interleaver #(.MAX_NCBPS(288)) dut (
    .clk_Modulation (clk),
    .reset          (rst),
    .io             (io)
  );

  typedef struct {
    bit b;
    bit sof;
  } exp_t;

  exp_t exp_q[$];
  int   sof_edge_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_n = 0;
  bit   pay[288];
  bit   prev_valid = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void chk(string nm, int act, int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endfunction

  // Reference model straight from the standard definition.
  function automatic int ncbps_model(int m);
    int nbpsc;
    nbpsc = (m == 0) ? 1 : (m == 1) ? 2 : (m == 2) ? 4 : 6;
    return 48 * nbpsc;
  endfunction

  function automatic int perm_j(int k, int n);
    int nbpsc, s, i;
    nbpsc = n / 48;
    s = (nbpsc / 2 > 1) ? nbpsc / 2 : 1;
    i = (n / 16) * (k % 16) + k / 16;
    return s * (i / s) + (i + n - (16 * i) / n) % s;
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (io.tx_interleave_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_bit", int'(io.tx_interleave_bit), int'(e.b));
          chk("out_sof", int'(io.tx_interleave_sof), int'(e.sof));
          if (e.sof) begin
            if (sof_edge_q.size() == 0) chk("sof_edge_missing", 1, 0);
            else chk("sof_latency_edge", edge_n, sof_edge_q.pop_front());
          end
        end
      end else begin
        chk("idle_bit_zero", int'(io.tx_interleave_bit) | int'(io.tx_interleave_sof), 0);
        if (prev_valid && exp_q.size() != 0 && !exp_q[0].sof)
          chk("burst_contiguous", 0, 1);
      end
      prev_valid = io.tx_interleave_valid;
    end
  end

  task automatic send_symbol(input int m, input int gap_pct, input bit wild_mod,
                             input bit expect_out);
    int   n;
    bit   ob[288];
    exp_t e;
    n = ncbps_model(m);
    for (int k = 0; k < n; k++) ob[perm_j(k, n)] = pay[k];
    if (expect_out) begin
      for (int j = 0; j < n; j++) begin
        e.b = ob[j];
        e.sof = (j == 0);
        exp_q.push_back(e);
      end
    end
    for (int k = 0; k < n; k++) begin
      while ($urandom_range(99) < gap_pct) begin
        io.tx_puncture_valid = 1'b0;
        io.tx_puncture_bit   = 1'($urandom);
        io.tx_Modulation     = wild_mod ? 2'($urandom) : 2'(m);
        @(posedge clk); #1;
      end
      io.tx_puncture_valid = 1'b1;
      io.tx_puncture_bit   = pay[k];
      io.tx_Modulation     = (k == 0 || !wild_mod) ? 2'(m) : 2'($urandom);
      @(posedge clk); #1;
    end
    if (expect_out) sof_edge_q.push_back(edge_n + 2);
  endtask

  task automatic idle_drain();
    io.tx_puncture_valid = 1'b0;
    io.tx_puncture_bit   = 1'b0;
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(negedge clk);
    chk("drain_remaining", exp_q.size(), 0);
    exp_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic set_one(input int k);
    foreach (pay[i]) pay[i] = 1'b0;
    pay[k] = 1'b1;
  endtask

  task automatic set_rand();
    foreach (pay[i]) pay[i] = 1'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    io.tx_Modulation     = 2'd0;
    io.tx_puncture_valid = 1'b0;
    io.tx_puncture_bit   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", int'(io.tx_interleave_valid), 0);
    chk("reset_bit",   int'(io.tx_interleave_bit), 0);
    chk("reset_sof",   int'(io.tx_interleave_sof), 0);
    chk("reset_err",   int'(io.tx_interleave_err), 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // single-bit placement checks
    set_one(1);  send_symbol(0, 0, 0, 1); idle_drain();
    set_one(1);  send_symbol(2, 0, 0, 1); idle_drain();
    set_one(12); send_symbol(2, 0, 0, 1); idle_drain();
    set_one(16); send_symbol(2, 0, 0, 1); idle_drain();
    set_one(1);  send_symbol(3, 0, 0, 1); idle_drain();
    set_one(2);  send_symbol(3, 0, 0, 1); idle_drain();

    // full random 64-QAM payload
    set_rand(); send_symbol(3, 0, 0, 1); idle_drain();

    // three back-to-back QPSK symbols
    for (int s = 0; s < 3; s++) begin
      set_rand();
      send_symbol(1, 0, 0, 1);
    end
    idle_drain();
    chk("err_after_b2b", int'(io.tx_interleave_err), 0);

    // gappy 16-QAM with tx_Modulation wandering mid-symbol
    for (int s = 0; s < 2; s++) begin
      set_rand();
      send_symbol(2, 50, 1, 1);
    end
    idle_drain();
    chk("err_after_gaps", int'(io.tx_interleave_err), 0);

    // overflow: a short BPSK symbol completes while the 64-QAM read is running
    set_rand(); send_symbol(3, 0, 0, 1);
    set_rand(); send_symbol(0, 0, 0, 0);
    idle_drain();
    chk("err_after_overflow", int'(io.tx_interleave_err), 1);
    set_rand(); send_symbol(0, 0, 0, 1); idle_drain();

    // reset in the middle of a 64-QAM read
    set_rand(); send_symbol(3, 0, 0, 1);
    io.tx_puncture_valid = 1'b0;
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_valid", int'(io.tx_interleave_valid), 0);
    chk("midreset_bit",   int'(io.tx_interleave_bit), 0);
    chk("midreset_sof",   int'(io.tx_interleave_sof), 0);
    chk("midreset_err",   int'(io.tx_interleave_err), 0);
    exp_q.delete();
    sof_edge_q.delete();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    set_rand(); send_symbol(0, 0, 0, 1); idle_drain();
    set_one(1); send_symbol(0, 0, 0, 1); idle_drain();

    chk("final_sof_queue_empty", sof_edge_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
